multicycle_ctrl: RTL and testbench

Control FSM that sequences a shared-resource RISC-V datapath over multiple cycles: PC, instruction register, register file, a single ALU and one memory port used for both fetch and data. It replaces the single-cycle decoder/ALU-op path with a sequenced controller that handles a variable-latency memory via a req/ready handshake. It also keeps a retired-instruction counter and traps on illegal opcodes or memory timeout.

---
 rtl/multicycle_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// Sequencing controller for a shared-resource RISC-V datapath: one memory port for
// fetch and data, a single ALU, a req/ready handshake with timeout, and a retire counter.
module multicycle_ctrl #(
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [6:0]       opcode_i,
  input  logic [2:0]       funct3_i,
  input  logic             zero_i,
  input  logic             mem_ready_i,
  output logic             pc_write_o,
  output logic             ir_write_o,
  output logic             reg_write_o,
  output logic             mem_req_o,
  output logic             mem_we_o,
  output logic [1:0]       alu_src_a_o,
  output logic [1:0]       alu_src_b_o,
  output logic [1:0]       alu_op_o,
  output logic             pc_src_o,
  output logic [1:0]       wb_sel_o,
  output logic [3:0]       state_o,
  output logic             illegal_o,
  output logic             bus_err_o,
  output logic [CNT_W-1:0] instret_o
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_EXEC_R = 4'd2,
    S_EXEC_I = 4'd3,
    S_ADDR   = 4'd4,
    S_MEM_RD = 4'd5,
    S_MEM_WR = 4'd6,
    S_WB_ALU = 4'd7,
    S_WB_MEM = 4'd8,
    S_BRANCH = 4'd9,
    S_JAL    = 4'd10,
    S_TRAP   = 4'd11
  } state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  // The counter only ever holds 0..MEM_TIMEOUT-1: the limit is recognised one
  // increment early so that a ready in that same cycle still wins.
  localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

  state_t            state;
  logic [WAIT_W-1:0] wait_cnt;
  logic              in_mem;
  logic              timeout_hit;
  logic              branch_taken;
  logic              retire;

  logic pc_write, ir_write, reg_write, mem_req, mem_we;

  assign in_mem       = (state == S_FETCH) || (state == S_MEM_RD) || (state == S_MEM_WR);
  assign timeout_hit  = (MEM_TIMEOUT != 0) && in_mem && !mem_ready_i && (wait_cnt == WAIT_LAST);
  assign branch_taken = ((funct3_i == 3'b000) && zero_i) || ((funct3_i == 3'b001) && !zero_i);
  assign retire       = (state == S_WB_ALU) || (state == S_WB_MEM) || (state == S_BRANCH) ||
                        (state == S_JAL) || ((state == S_MEM_WR) && mem_ready_i);

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // in this block sees the pre-edge values of the others.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state     <= S_FETCH;
      wait_cnt  <= '0;
      instret_o <= '0;
      illegal_o <= 1'b0;
      bus_err_o <= 1'b0;
    end else begin
      // Cleared outside memory states and on completion, so each access starts at zero.
      if (!in_mem || mem_ready_i) wait_cnt <= '0;
      else if (MEM_TIMEOUT != 0)  wait_cnt <= wait_cnt + WAIT_W'(1);

      if (retire) instret_o <= instret_o + CNT_W'(1);

      if (timeout_hit) begin
        state     <= S_TRAP;
        bus_err_o <= 1'b1;
      end else begin
        case (state)
          S_FETCH:  if (mem_ready_i) state <= S_DECODE;
          S_DECODE: begin
            if (opcode_i == OP_R)                             state <= S_EXEC_R;
            else if (opcode_i == OP_I)                        state <= S_EXEC_I;
            else if (opcode_i == OP_LOAD || opcode_i == OP_STORE) state <= S_ADDR;
            else if (opcode_i == OP_BRANCH && funct3_i[2:1] == 2'b00) state <= S_BRANCH;
            else if (opcode_i == OP_JAL)                      state <= S_JAL;
            else begin
              state     <= S_TRAP;
              illegal_o <= 1'b1;
            end
          end
          S_EXEC_R, S_EXEC_I: state <= S_WB_ALU;
          S_ADDR:   state <= (opcode_i == OP_STORE) ? S_MEM_WR : S_MEM_RD;
          S_MEM_RD: if (mem_ready_i) state <= S_WB_MEM;
          S_MEM_WR: if (mem_ready_i) state <= S_FETCH;
          S_WB_ALU, S_WB_MEM, S_BRANCH, S_JAL: state <= S_FETCH;
          default:  state <= S_TRAP;
        endcase
      end
    end
  end

  // NOTE: every output gets a default before the case, so no state can infer a latch.
  always_comb begin
    pc_write    = 1'b0;
    ir_write    = 1'b0;
    reg_write   = 1'b0;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    alu_src_a_o = 2'b00;
    alu_src_b_o = 2'b00;
    alu_op_o    = 2'b00;
    pc_src_o    = 1'b0;
    wb_sel_o    = 2'b00;
    case (state)
      S_FETCH: begin
        mem_req     = 1'b1;
        alu_src_b_o = 2'b01;
        ir_write    = mem_ready_i;
        pc_write    = mem_ready_i;
      end
      S_DECODE: begin
        alu_src_a_o = 2'b01;
        alu_src_b_o = 2'b10;
      end
      S_EXEC_R: begin
        alu_src_a_o = 2'b10;
        alu_op_o    = 2'b10;
      end
      S_EXEC_I: begin
        alu_src_a_o = 2'b10;
        alu_src_b_o = 2'b10;
        alu_op_o    = 2'b10;
      end
      S_ADDR: begin
        alu_src_a_o = 2'b10;
        alu_src_b_o = 2'b10;
      end
      S_MEM_RD: mem_req = 1'b1;
      S_MEM_WR: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
      end
      S_WB_ALU: reg_write = 1'b1;
      S_WB_MEM: begin
        reg_write = 1'b1;
        wb_sel_o  = 2'b01;
      end
      S_BRANCH: begin
        alu_src_a_o = 2'b10;
        alu_op_o    = 2'b01;
        pc_write    = branch_taken;
        pc_src_o    = branch_taken;
      end
      S_JAL: begin
        reg_write = 1'b1;
        wb_sel_o  = 2'b10;
        pc_write  = 1'b1;
        pc_src_o  = 1'b1;
      end
      default: ;
    endcase
  end

  // Reset lands in FETCH, whose Moore decode requests memory; the strobes are
  // masked so an aborted access leaves no partial write behind.
  assign pc_write_o  = pc_write  && !rst_i;
  assign ir_write_o  = ir_write  && !rst_i;
  assign reg_write_o = reg_write && !rst_i;
  assign mem_req_o   = mem_req   && !rst_i;
  assign mem_we_o    = mem_we    && !rst_i;
  assign state_o     = state;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomised bench for multicycle_ctrl: each instruction is expanded into its expected
// per-cycle output trace from the instruction class and memory latencies.
module tb_multicycle_ctrl;
  localparam int CW = 4;
  localparam int TO = 16;

  localparam logic [3:0] FETCH = 4'd0, DECODE = 4'd1, EXEC_R = 4'd2, EXEC_I = 4'd3,
                         ADDR = 4'd4, MEM_RD = 4'd5, MEM_WR = 4'd6, WB_ALU = 4'd7,
                         WB_MEM = 4'd8, BRANCH = 4'd9, JAL = 4'd10, TRAP = 4'd11;

  localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_LD = 7'b0000011,
                         OP_ST = 7'b0100011, OP_BR = 7'b1100011, OP_JAL = 7'b1101111;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic [6:0]    opcode_i = '0;
  logic [2:0]    funct3_i = '0;
  logic          zero_i = 1'b0;
  logic          mem_ready_i = 1'b0;
  logic          pc_write_o, ir_write_o, reg_write_o, mem_req_o, mem_we_o, pc_src_o;
  logic [1:0]    alu_src_a_o, alu_src_b_o, alu_op_o, wb_sel_o;
  logic [3:0]    state_o;
  logic          illegal_o, bus_err_o;
  logic [CW-1:0] instret_o;

  always #5 clk_i = ~clk_i;

  multicycle_ctrl #(.CNT_W(CW), .MEM_TIMEOUT(TO)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .opcode_i(opcode_i), .funct3_i(funct3_i),
    .zero_i(zero_i), .mem_ready_i(mem_ready_i), .pc_write_o(pc_write_o),
    .ir_write_o(ir_write_o), .reg_write_o(reg_write_o), .mem_req_o(mem_req_o),
    .mem_we_o(mem_we_o), .alu_src_a_o(alu_src_a_o), .alu_src_b_o(alu_src_b_o),
    .alu_op_o(alu_op_o), .pc_src_o(pc_src_o), .wb_sel_o(wb_sel_o), .state_o(state_o),
    .illegal_o(illegal_o), .bus_err_o(bus_err_o), .instret_o(instret_o)
  );

  typedef struct packed {
    logic [3:0]    st;
    logic          pcw, irw, rw, req, we;
    logic [1:0]    sa, sb, op;
    logic          pcs;
    logic [1:0]    wb;
    logic          ill, berr;
    logic [CW-1:0] ret;
  } obs_t;

  int n_total = 0;
  int n_bad   = 0;

  // Reference model state
  int         m_ret  = 0;
  bit         m_ill  = 0;
  bit         m_berr = 0;
  logic [6:0] cur_op = '0;
  logic [2:0] cur_f3 = '0;
  logic       cur_zero = 1'b0;

  function automatic obs_t sample();
    obs_t o;
    o.st = state_o; o.pcw = pc_write_o; o.irw = ir_write_o; o.rw = reg_write_o;
    o.req = mem_req_o; o.we = mem_we_o; o.sa = alu_src_a_o; o.sb = alu_src_b_o;
    o.op = alu_op_o; o.pcs = pc_src_o; o.wb = wb_sel_o; o.ill = illegal_o;
    o.berr = bus_err_o; o.ret = instret_o;
    return o;
  endfunction

  function automatic obs_t base(input logic [3:0] st);
    obs_t e = '0;
    e.st = st; e.ret = CW'(m_ret); e.ill = m_ill; e.berr = m_berr;
    return e;
  endfunction

  task automatic compare(input obs_t e, input string tag);
    obs_t got = sample();
    n_total++;
    if (got !== e) begin
      n_bad++;
      $display("FAIL %s: got state=%0d vec=%h, expected state=%0d vec=%h",
               tag, got.st, got, e.st, e);
    end
  endtask

  // One clock cycle: inputs applied at negedge, outputs checked 1ns later.
  task automatic cyc(input obs_t e, input logic rdy, input bit zero_used, input string tag);
    @(negedge clk_i);
    opcode_i    = cur_op;
    funct3_i    = cur_f3;
    mem_ready_i = rdy;
    zero_i      = zero_used ? cur_zero : 1'($urandom);
    #1;
    compare(e, tag);
  endtask

  task automatic model_reset();
    m_ret = 0; m_ill = 0; m_berr = 0;
  endtask

  function automatic obs_t reset_view();
    obs_t e = base(FETCH);
    e.sb = 2'b01;
    return e;
  endfunction

  task automatic do_reset();
    @(negedge clk_i);
    rst_i = 1'b1;
    mem_ready_i = 1'b0;
    model_reset();
    #1 compare(reset_view(), "reset_async");
    @(posedge clk_i);
    #2 compare(reset_view(), "reset_held");
    rst_i = 1'b0;
  endtask

  task automatic retire();
    m_ret = (m_ret + 1) % (1 << CW);
  endtask

  // A memory access lasts delay+1 cycles, unless no ready arrives within TO cycles.
  task automatic access(input logic [3:0] st, input int delay, output bit timed_out);
    int n = (delay < TO) ? delay + 1 : TO;
    timed_out = (delay >= TO);
    for (int i = 0; i < n; i++) begin
      obs_t e = base(st);
      logic rdy = (i == delay);
      e.req = 1'b1;
      e.we  = (st == MEM_WR);
      if (st == FETCH) begin
        e.sb = 2'b01; e.irw = rdy; e.pcw = rdy;
      end
      cyc(e, rdy, 1'b0, "access");
    end
    if (timed_out) m_berr = 1;
  endtask

  task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic z,
                           input int fdelay, input int mdelay, output bit trapped);
    obs_t e;
    bit   to;
    cur_op = op; cur_f3 = f3; cur_zero = z;
    trapped = 1;
    access(FETCH, fdelay, to);
    if (to) return;
    e = base(DECODE); e.sa = 2'b01; e.sb = 2'b10;
    cyc(e, 1'($urandom), 1'b0, "decode");
    if (op == OP_R || op == OP_I) begin
      e = base(op == OP_R ? EXEC_R : EXEC_I);
      e.sa = 2'b10; e.sb = (op == OP_R) ? 2'b00 : 2'b10; e.op = 2'b10;
      cyc(e, 1'($urandom), 1'b0, "exec");
      e = base(WB_ALU); e.rw = 1'b1;
      cyc(e, 1'($urandom), 1'b0, "wb_alu");
    end else if (op == OP_LD || op == OP_ST) begin
      e = base(ADDR); e.sa = 2'b10; e.sb = 2'b10;
      cyc(e, 1'($urandom), 1'b0, "addr");
      access(op == OP_ST ? MEM_WR : MEM_RD, mdelay, to);
      if (to) return;
      if (op == OP_LD) begin
        e = base(WB_MEM); e.rw = 1'b1; e.wb = 2'b01;
        cyc(e, 1'($urandom), 1'b0, "wb_mem");
      end
    end else if (op == OP_BR && (f3 == 3'b000 || f3 == 3'b001)) begin
      bit taken = (f3 == 3'b000) ? z : !z;
      e = base(BRANCH); e.sa = 2'b10; e.op = 2'b01; e.pcw = taken; e.pcs = taken;
      cyc(e, 1'($urandom), 1'b1, "branch");
    end else if (op == OP_JAL) begin
      e = base(JAL); e.rw = 1'b1; e.wb = 2'b10; e.pcw = 1'b1; e.pcs = 1'b1;
      cyc(e, 1'($urandom), 1'b0, "jal");
    end else begin
      m_ill = 1;
      return;
    end
    retire();
    trapped = 0;
  endtask

  task automatic trap_hold(input int n);
    for (int i = 0; i < n; i++) begin
      cur_op = 7'($urandom); cur_f3 = 3'($urandom);
      cyc(base(TRAP), 1'($urandom), 1'b0, "trap_hold");
    end
  endtask

  task automatic test_reset();
    do_reset();
  endtask

  task automatic test_r_type();
    bit t;
    run_instr(OP_R, 3'b000, 1'b0, 0, 0, t);
  endtask

  task automatic test_load_delayed();
    bit t;
    run_instr(OP_LD, 3'b010, 1'b0, 0, 3, t);
  endtask

  task automatic test_branch();
    bit t;
    run_instr(OP_BR, 3'b000, 1'b1, 1, 0, t);
    run_instr(OP_BR, 3'b001, 1'b1, 0, 0, t);
    run_instr(OP_BR, 3'b001, 1'b0, 2, 0, t);
  endtask

  task automatic test_illegal();
    bit t;
    run_instr(7'b1111111, 3'b000, 1'b0, 0, 0, t);
    trap_hold(20);
    do_reset();
    run_instr(OP_BR, 3'b010, 1'b0, 0, 0, t);
    trap_hold(3);
    do_reset();
  endtask

  task automatic test_timeout();
    bit t;
    run_instr(OP_R, 3'b000, 1'b0, 100, 0, t);
    trap_hold(4);
    do_reset();
    run_instr(OP_I, 3'b000, 1'b0, TO - 1, 0, t);
    run_instr(OP_ST, 3'b010, 1'b0, 0, TO - 1, t);
    run_instr(OP_LD, 3'b010, 1'b0, 0, TO, t);
    trap_hold(3);
    do_reset();
  endtask

  task automatic test_reset_mid_store();
    obs_t e;
    bit   t;
    run_instr(OP_JAL, 3'b000, 1'b0, 0, 0, t);
    cur_op = OP_ST;
    run_instr(OP_R, 3'b000, 1'b0, 0, 0, t);
    cur_op = OP_ST; cur_f3 = 3'b010;
    e = base(FETCH); e.req = 1'b1; e.sb = 2'b01; e.irw = 1'b1; e.pcw = 1'b1;
    cyc(e, 1'b1, 1'b0, "st_fetch");
    e = base(DECODE); e.sa = 2'b01; e.sb = 2'b10;
    cyc(e, 1'b0, 1'b0, "st_decode");
    e = base(ADDR); e.sa = 2'b10; e.sb = 2'b10;
    cyc(e, 1'b0, 1'b0, "st_addr");
    e = base(MEM_WR); e.req = 1'b1; e.we = 1'b1;
    cyc(e, 1'b0, 1'b0, "st_wait");
    #2 rst_i = 1'b1;
    mem_ready_i = 1'b1;
    model_reset();
    #1 compare(reset_view(), "reset_mid_store");
    @(posedge clk_i);
    #2 compare(reset_view(), "reset_mid_store_held");
    mem_ready_i = 1'b0;
    rst_i = 1'b0;
  endtask

  task automatic test_wrap();
    bit t;
    do_reset();
    for (int i = 0; i < (1 << CW); i++) run_instr(OP_R, 3'b000, 1'b0, 0, 0, t);
    @(negedge clk_i);
    n_total++;
    if (instret_o !== CW'(m_ret) || m_ret != 0) begin
      n_bad++;
      $display("FAIL wrap: instret got %0d, expected 0", instret_o);
    end
  endtask

  task automatic test_random();
    logic [6:0] legal [7] = '{OP_R, OP_I, OP_LD, OP_ST, OP_BR, OP_BR, OP_JAL};
    logic [6:0] bad   [6] = '{7'h7F, 7'h00, 7'h37, 7'h17, 7'h67, 7'h73};
    for (int i = 0; i < 200; i++) begin
      logic [6:0] op;
      logic [2:0] f3 = 3'($urandom);
      int         k  = $urandom_range(0, 6);
      int         fd = ($urandom_range(0, 19) == 0) ? $urandom_range(14, 17) : $urandom_range(0, 3);
      int         md = ($urandom_range(0, 19) == 0) ? $urandom_range(14, 17) : $urandom_range(0, 3);
      bit         t;
      op = legal[k];
      if (k == 4) f3 = 3'b000;
      if (k == 5) f3 = 3'b001;
      if ($urandom_range(0, 29) == 0) op = bad[$urandom_range(0, 5)];
      run_instr(op, f3, 1'($urandom), fd, md, t);
      if (t) begin
        trap_hold($urandom_range(1, 4));
        do_reset();
      end
    end
  endtask

  initial begin
    test_reset();
    test_r_type();
    test_load_delayed();
    test_branch();
    test_illegal();
    test_timeout();
    test_reset_mid_store();
    test_wrap();
    test_random();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
